// File: rtl/mac_arbiter_if.sv
// Requester-side port bundle for the shared MAC: one instance per filter engine.
// Handshake: a term transfers on a rising edge where req & gnt; the requester holds
// req, a, b, first and last stable until gnt, and may drop req before gnt with no effect.
interface mac_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 40
) ();
    logic          req;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          first;
    logic          last;
    logic          gnt;
    logic [AW-1:0] acc;
    logic          acc_valid;
    logic          err;

    modport master (
        output req, a, b, first, last,
        input  gnt, acc, acc_valid, err
    );

    modport slave (
        input  req, a, b, first, last,
        output gnt, acc, acc_valid, err
    );
endinterface

// File: rtl/mac_arbiter.sv
// Shares one signed DWxDW multiplier and accumulate path between the halfband and FIR
// engines: round-robin grant, multiply stage, accumulate stage, one accumulator per requester.
module mac_arbiter #(
    parameter int DW = 16,
    parameter int AW = 40
) (
    input  logic            clk,
    input  logic            reset_n,
    mac_arbiter_if.slave    hb,
    mac_arbiter_if.slave    fir,
    output logic            busy,
    output logic            dbg_last_grant
);

    localparam logic [0:0] TAG_HB  = 1'b0;
    localparam logic [0:0] TAG_FIR = 1'b1;

    // Arbitration state: the requester that won the most recent transfer.
    logic [0:0] last_grant;

    logic hb_win;
    logic fir_win;
    logic xfer;

    logic [DW-1:0]          a_sel;
    logic [DW-1:0]          b_sel;
    logic signed [2*DW-1:0] a_ext;
    logic signed [2*DW-1:0] b_ext;
    logic signed [2*DW-1:0] prod;

    // Stage 1 registers
    logic                   v1;
    logic [0:0]             tag1;
    logic                   first1;
    logic                   last1;
    logic signed [2*DW-1:0] p1;

    // Per-requester accumulation state
    logic [AW-1:0] acc_hb;
    logic [AW-1:0] acc_fir;
    logic          in_seq_hb;
    logic          in_seq_fir;

    // Stage 2 datapath
    logic [AW-1:0] s_ext;
    logic [AW-1:0] acc_cur;
    logic [AW-1:0] acc_new;
    logic          in_seq_cur;
    logic          in_seq_next;
    logic          proto_err;

    always_comb begin
        hb_win  = hb.req  & (~fir.req | (last_grant == TAG_FIR));
        fir_win = fir.req & (~hb.req  | (last_grant == TAG_HB));
        xfer    = hb_win | fir_win;
    end

    assign hb.gnt         = hb_win;
    assign fir.gnt        = fir_win;
    assign dbg_last_grant = last_grant;

    always_comb begin
        a_sel = fir_win ? fir.a : hb.a;
        b_sel = fir_win ? fir.b : hb.b;
        a_ext = {{DW{a_sel[DW-1]}}, a_sel};
        b_ext = {{DW{b_sel[DW-1]}}, b_sel};
        prod  = a_ext * b_ext;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= TAG_FIR;
            v1         <= 1'b0;
            tag1       <= TAG_HB;
            first1     <= 1'b0;
            last1      <= 1'b0;
            p1         <= '0;
        end else begin
            v1 <= xfer;
            if (xfer) begin
                p1         <= prod;
                tag1       <= fir_win ? TAG_FIR : TAG_HB;
                first1     <= fir_win ? fir.first : hb.first;
                last1      <= fir_win ? fir.last  : hb.last;
                last_grant <= fir_win ? TAG_FIR : TAG_HB;
            end
        end
    end

    // A term with first restarts from its own product even mid-sequence; a term
    // without first outside a sequence accumulates onto whatever was left behind.
    always_comb begin
        s_ext       = {{(AW-2*DW){p1[2*DW-1]}}, p1};
        acc_cur     = (tag1 == TAG_FIR) ? acc_fir : acc_hb;
        in_seq_cur  = (tag1 == TAG_FIR) ? in_seq_fir : in_seq_hb;
        acc_new     = first1 ? s_ext : (acc_cur + s_ext);
        proto_err   = first1 ? in_seq_cur : ~in_seq_cur;
        in_seq_next = last1 ? 1'b0 : (first1 ? 1'b1 : in_seq_cur);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_hb        <= '0;
            acc_fir       <= '0;
            in_seq_hb     <= 1'b0;
            in_seq_fir    <= 1'b0;
            hb.acc        <= '0;
            hb.acc_valid  <= 1'b0;
            hb.err        <= 1'b0;
            fir.acc       <= '0;
            fir.acc_valid <= 1'b0;
            fir.err       <= 1'b0;
        end else begin
            hb.acc_valid  <= 1'b0;
            fir.acc_valid <= 1'b0;
            if (v1) begin
                if (tag1 == TAG_FIR) begin
                    acc_fir    <= acc_new;
                    in_seq_fir <= in_seq_next;
                    if (proto_err) begin
                        fir.err <= 1'b1;
                    end
                    if (last1) begin
                        fir.acc       <= acc_new;
                        fir.acc_valid <= 1'b1;
                    end
                end else begin
                    acc_hb    <= acc_new;
                    in_seq_hb <= in_seq_next;
                    if (proto_err) begin
                        hb.err <= 1'b1;
                    end
                    if (last1) begin
                        hb.acc       <= acc_new;
                        hb.acc_valid <= 1'b1;
                    end
                end
            end
        end
    end

    // The accumulate write always lands on the edge after v1, so v1 alone marks it pending.
    assign busy = hb.req | fir.req | v1;

endmodule

// File: doc/mac_arbiter.md
Name: mac_arbiter

Overview:
- Shares one signed 16x16 multiplier and accumulate path between two filter requesters: the halfband (hb_*) and the FIR (fir_*).
- Sits in the clk domain between the hb and fir filter engines, replacing their private multipliers.
- Round-robin arbitration, 2-stage pipeline, a separate accumulator per requester.
- Delivers one completed dot-product result per requester sequence.

Parameters:
- DW, 16, operand width (signed two's complement).
- AW, 40, accumulator/result width (signed); covers up to 256 full-scale terms without overflow.

Ports:
- clk  in  1  system clock (1.536 MHz filter clock).
- reset_n  in  1  asynchronous active-low reset.
- hb_req  in  1  halfband requests one MAC term.
- hb_a  in  DW  halfband operand A (sample).
- hb_b  in  DW  halfband operand B (coefficient).
- hb_first  in  1  term starts a new accumulation.
- hb_last  in  1  term ends the accumulation.
- hb_gnt  out  1  term accepted this cycle (combinational).
- hb_acc  out  AW  last completed halfband result.
- hb_acc_valid  out  1  one-cycle pulse: hb_acc updated.
- hb_err  out  1  sticky protocol error, halfband.
- fir_req, fir_a, fir_b, fir_first, fir_last, fir_gnt, fir_acc, fir_acc_valid, fir_err: same as the hb_* ports, for the FIR.
- busy  out  1  any req high or any pipeline stage valid.

Behaviour:
- Reset: asynchronous, active-low. All outputs and internal state clear to 0; last_grant = FIR, so hb wins the first tie.
- Reset mid-operation discards in-flight terms and partial accumulators, with no acc_valid pulse.
- Handshake:
  - A term transfers on a rising edge where x_req & x_gnt.
  - The requester holds req, a, b, first and last stable until gnt.
  - Dropping req before gnt is legal and has no effect.
- Arbitration (combinational, same cycle):
  - Only one req high: grant it.
  - Both high: grant the requester not equal to last_grant.
  - last_grant updates on every transfer.
  - Never both gnt high. Under continuous contention, grants strictly alternate, so the maximum wait is 1 cycle.
- Stage 1, registered on the transfer edge E0:
  - p = a*b, full 2*DW signed.
  - Also registers tag (0 = hb, 1 = fir), first, last, v1 = 1.
  - v1 = 0 on cycles with no transfer.
- Stage 2, on edge E1 when v1:
  - s = sign_extend(p) to AW.
  - new = first ? s : acc[tag] + s; acc[tag] <= new.
  - Accumulation wraps modulo 2^AW; no saturation.
  - If last: x_acc <= new and x_acc_valid = 1 for exactly the cycle after E1. Latency is 2 edges from transfer to valid result.
- x_acc holds its value until the next completed sequence of that requester.
- first & last on the same term: result = sign_extend(p).
- Accumulators are independent: interleaved hb/fir terms never corrupt each other.
- Both requesters can complete on consecutive cycles, giving back-to-back valid pulses on different ports.
- Protocol errors: a per-requester in_seq flag is set by a first-without-last term and cleared by a last term.
  - first while in_seq: accumulation restarts from s and x_err is set.
  - A term without first while not in_seq: accumulates onto the stale acc and x_err is set.
  - x_err is sticky and cleared only by reset.
- busy = hb_req | fir_req | v1 | (stage-2 write pending).

Test Plan:
- Reset release, hb only, 3 terms (2*3 first, -4*5, 7*1 last) -> hb_gnt each cycle; hb_acc = -7 with hb_acc_valid pulsing exactly 2 edges after the last transfer; fir_* stay 0.
- Both req held continuously, each sending 4-term sequences of 1*1 -> grants alternate hb, fir, hb, ...; both accumulators = 4; valid pulses on consecutive cycles; hb_err = fir_err = 0.
- Single term first & last, a = -32768, b = -32768 -> acc = +1073741824 (no sign loss).
- 256 terms of 32767*32767 -> acc = 274861129984, exact with no wrap at AW = 40.
- fir issues first, then first again without last -> fir_err = 1 and stays 1; the result equals the second sequence only; hb is unaffected.
- Assert reset_n low one cycle after a transfer with v1 = 1 -> no acc_valid pulse; accs and outputs = 0; busy = 0; the next tie is granted to hb.
